// File: rtl/subunit_rr_arbiter_pkg.sv
// subunit_rr_arbiter_pkg: shared FSM state, ID width and rotating first-set search
package subunit_rr_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

   localparam int MAX_REQ = 16;
   localparam int DEF_REQ = 5;
   localparam int ID_W    = $clog2(DEF_REQ);

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } pick_t;

   // First set bit at or after ptr, scanning upward modulo n. Offsets are
   // walked from the far end so the nearest hit is the last one written.
   function automatic pick_t rr_first(input logic [MAX_REQ-1:0] req, input logic [3:0] ptr, input int n);
      pick_t p;
      int    j;
      p = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < n) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (req[j[3:0]]) p = '{found: 1'b1, idx: j[3:0]};
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/subunit_rr_arbiter_if.sv
// subunit_rr_arbiter_if: request/grant bundle between the leaf sub-units and the arbiter
interface subunit_rr_arbiter_if
   import subunit_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_REQ,
   parameter int CNT_W   = 16
);
   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic [IW-1:0]      gnt_id;
   logic               timeout;
   logic [CNT_W-1:0]   grant_cnt;

   modport master (output req, input gnt, gnt_valid, gnt_id, timeout, grant_cnt);
   modport slave  (input req, output gnt, gnt_valid, gnt_id, timeout, grant_cnt);
endinterface

// File: rtl/subunit_rr_arbiter_rr_pick.sv
// subunit_rr_arbiter_rr_pick: combinational round-robin priority search
module subunit_rr_arbiter_rr_pick
   import subunit_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_REQ,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      idx
);
   pick_t p;

   // search upward from ptr with wrap; idx is meaningless when found is low
   always_comb begin
      p     = rr_first(MAX_REQ'(req), 4'(ptr), NUM_REQ);
      found = p.found;
      idx   = IW'(p.idx);
   end
endmodule

// File: rtl/subunit_rr_arbiter.sv
// subunit_rr_arbiter: round-robin arbiter with hold-limit timeout and one-cycle recovery gap
module subunit_rr_arbiter
   import subunit_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = DEF_REQ,
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 16
) (
   input logic clk,
   input logic rst_n,
   subunit_rr_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);

   state_t             state, state_nxt;
   logic [IW-1:0]      rr_ptr, owner, pick_idx, sel;
   logic [7:0]         hold_cnt;
   logic               pick_found, owner_req, hold_end;
   logic [NUM_REQ-1:0] gnt, gnt_nxt;
   logic [IW-1:0]      gnt_id;
   logic               gnt_valid, timeout, timeout_nxt;
   logic [CNT_W-1:0]   grant_cnt;

   assign owner_req = bus.req[owner];
   assign hold_end  = hold_cnt == 8'(HOLD_MAX - 1);

   assign bus.gnt       = gnt;
   assign bus.gnt_valid = gnt_valid;
   assign bus.gnt_id    = gnt_id;
   assign bus.timeout   = timeout;
   assign bus.grant_cnt = grant_cnt;

   subunit_rr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req   (bus.req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   // next state: arbitrate only in IDLE, leave GRANT on release or hold limit
   always_comb begin
      state_nxt = state == IDLE  ? (pick_found ? GRANT : IDLE) :
                  state == GRANT ? ((!owner_req || hold_end) ? RECOVER : GRANT) :
                  IDLE;
   end

   // next-cycle outputs, registered below so req never reaches gnt combinationally
   always_comb begin
      sel         = state == IDLE ? pick_idx : owner;
      gnt_nxt     = state_nxt == GRANT ? NUM_REQ'(1) << sel : '0;
      timeout_nxt = state == GRANT && state_nxt == RECOVER && owner_req;
   end

   // registered grant outputs; reset clears them asynchronously with no timeout pulse
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         timeout   <= 1'b0;
      end else begin
         gnt       <= gnt_nxt;
         gnt_valid <= |gnt_nxt;
         gnt_id    <= state_nxt == GRANT ? sel : '0;
         timeout   <= timeout_nxt;
      end

   // owner capture, hold length and rotation pointer advanced in RECOVER
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         owner    <= '0;
         hold_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         if (state == IDLE && pick_found) begin
            owner    <= pick_idx;
            hold_cnt <= '0;
         end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 8'd1;
         end
         if (state == RECOVER) rr_ptr <= owner == IW'(NUM_REQ - 1) ? '0 : owner + IW'(1);
      end

   // saturating count of grants issued
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) grant_cnt <= '0;
      else if (state == IDLE && pick_found && !(&grant_cnt)) grant_cnt <= grant_cnt + CNT_W'(1);

endmodule

// File: tb/tb_subunit_rr_arbiter.sv
// tb_subunit_rr_arbiter: directed and random checks against a behavioural arbitration model
module tb_subunit_rr_arbiter;
   localparam int N    = 5;
   localparam int HOLD = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   to_seen = 0;

   int   m_own, m_len, m_wait, m_ptr, m_cnt;
   logic m_to;

   subunit_rr_arbiter_if #(.NUM_REQ(N), .CNT_W(16)) bus ();
   subunit_rr_arbiter_if #(.NUM_REQ(N), .CNT_W(4))  bus2 ();

   subunit_rr_arbiter #(.NUM_REQ(N), .HOLD_MAX(HOLD), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   subunit_rr_arbiter #(.NUM_REQ(N), .HOLD_MAX(2), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst2_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_own  = -1;
      m_len  = 0;
      m_wait = 0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_to   = 1'b0;
   endtask

   // one clock edge of the arbitration rules, using the req sampled at that edge
   task automatic m_step(input logic [N-1:0] r);
      logic hit;
      m_to = 1'b0;
      if (m_own >= 0) begin
         if (!r[m_own] || m_len == HOLD) begin
            m_to   = r[m_own];
            m_ptr  = (m_own + 1) % N;
            m_own  = -1;
            m_wait = 1;
         end else begin
            m_len++;
         end
      end else if (m_wait != 0) begin
         m_wait = 0;
      end else begin
         hit = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!hit && r[(m_ptr + k) % N]) begin
               hit   = 1'b1;
               m_own = (m_ptr + k) % N;
               m_len = 1;
               if (m_cnt < 65535) m_cnt++;
            end
         end
      end
   endtask

   task automatic cyc(input logic [N-1:0] r);
      bus.req = r;
      @(posedge clk);
      if (rst_n) m_step(r);
      #1;
      chk("gnt",       32'(bus.gnt),       m_own >= 0 ? 32'd1 << m_own : 32'd0);
      chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_own >= 0));
      chk("gnt_id",    32'(bus.gnt_id),    32'(m_own >= 0 ? m_own : 0));
      chk("timeout",   32'(bus.timeout),   32'(m_to));
      chk("grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
      if (bus.timeout) to_seen++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      bus.req = '0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int           order[$];
      logic         prev;
      logic [N-1:0] r;
      int           run;
      m_reset();
      bus.req  = '0;
      bus2.req = '1;
      repeat (2) @(negedge clk);
      chk("rst_gnt",       32'(bus.gnt),       32'd0);
      chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
      chk("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
      chk("rst_timeout",   32'(bus.timeout),   32'd0);
      chk("rst_grant_cnt", 32'(bus.grant_cnt), 32'd0);
      rst_n = 1'b1;

      cyc(5'b00100);
      chk("single_first", 32'(bus.gnt), 32'h4);
      repeat (2) cyc(5'b00100);
      chk("single_id", 32'(bus.gnt_id), 32'd2);
      cyc(5'b00000);
      chk("single_release", 32'(bus.gnt), 32'd0);
      repeat (2) cyc(5'b00000);
      chk("single_cnt", 32'(bus.grant_cnt), 32'd1);

      do_reset();
      prev = 1'b0;
      for (int c = 0; c < 60 && order.size() < 6; c++) begin
         r = '1;
         if (m_own >= 0 && m_len >= 2) r[m_own] = 1'b0;
         cyc(r);
         if (bus.gnt_valid && !prev) order.push_back(int'(bus.gnt_id));
         prev = bus.gnt_valid;
      end
      chk("rr_count", 32'(order.size()), 32'd6);
      for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % N));

      do_reset();
      to_seen = 0;
      run = 0;
      repeat (18) begin
         cyc(5'b00010);
         if (bus.gnt[1]) run++;
      end
      chk("hold_len", 32'(run), 32'd16);
      chk("timeout_once", 32'(to_seen), 32'd1);
      cyc(5'b00010);
      chk("regrant", 32'(bus.gnt), 32'h2);
      repeat (3) cyc(5'b00000);

      do_reset();
      cyc(5'b10000);
      chk("wrap_owner", 32'(bus.gnt_id), 32'd4);
      repeat (2) cyc(5'b10001);
      cyc(5'b00001);
      chk("wrap_recover", 32'(bus.gnt), 32'd0);
      cyc(5'b00001);
      chk("wrap_idle", 32'(bus.gnt), 32'd0);
      cyc(5'b00001);
      chk("wrap_gnt", 32'(bus.gnt), 32'h1);
      repeat (3) cyc(5'b00000);

      do_reset();
      repeat (3) cyc(5'b01000);
      chk("mid_owner", 32'(bus.gnt), 32'h8);
      #3 rst_n = 1'b0;
      #2;
      chk("async_gnt",       32'(bus.gnt),       32'd0);
      chk("async_gnt_valid", 32'(bus.gnt_valid), 32'd0);
      chk("async_timeout",   32'(bus.timeout),   32'd0);
      m_reset();
      bus.req = 5'b01001;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(5'b01001);
      chk("post_reset_gnt", 32'(bus.gnt), 32'h1);
      repeat (2) cyc(5'b01001);
      repeat (3) cyc(5'b00000);

      do_reset();
      r = '0;
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom);
         cyc(r);
      end

      @(negedge clk);
      rst2_n = 1'b1;
      repeat (8) @(posedge clk);
      #1 chk("sat_mid", 32'(bus2.grant_cnt), 32'd2);
      repeat (80) @(posedge clk);
      #1 chk("sat_top", 32'(bus2.grant_cnt), 32'hF);
      repeat (8) @(posedge clk);
      #1 chk("sat_hold", 32'(bus2.grant_cnt), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/subunit_rr_arbiter.md
# subunit_rr_arbiter

Round-robin arbiter that shares one resource port among the five leaf sub-units instantiated under a common parent in the sa8 hierarchy level. It grants exactly one requester at a time and holds the grant until release or a hold-limit timeout. A one-cycle recovery gap separates consecutive grants. It sits beside the leaf instances inside the parent module and drives their grant lines directly.

## Interface
- NUM_REQ, 5, number of requesters (2..16)
- HOLD_MAX, 16, maximum grant length in cycles (2..255)
- CNT_W, 16, width of grant counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  level request per requester; held until served
- gnt  out  NUM_REQ  one-hot grant, registered
- gnt_valid  out  1  OR of gnt
- gnt_id  out  $clog2(NUM_REQ)  index of current owner; 0 when gnt_valid=0
- timeout  out  1  one-cycle pulse when a grant is revoked by HOLD_MAX
- grant_cnt  out  CNT_W  number of grants issued, saturating at all-ones

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- FSM states: IDLE, GRANT, RECOVER.
- IDLE: if any req bit is set, select the first set index at or after rr_ptr, scanning upward modulo NUM_REQ. Enter GRANT with gnt set to that index, hold_cnt=0, grant_cnt incremented unless saturated. If no bit is set, stay in IDLE.
- GRANT: the grant holds while req[owner]=1 and hold_cnt<HOLD_MAX-1. hold_cnt increments each cycle.
  - If req[owner]=0, go to RECOVER.
  - If hold_cnt==HOLD_MAX-1 with req[owner] still 1, go to RECOVER and pulse timeout in the same transition.
- RECOVER: gnt=0 for exactly one cycle. Set rr_ptr=(owner+1) mod NUM_REQ, then go to IDLE. Arbitration resumes in IDLE on the following cycle.
- A timed-out requester that keeps req high is treated as a fresh request. It is served again only after all other pending requesters, per rr_ptr.
- Requests from non-owners during GRANT or RECOVER are ignored until IDLE. Requests do not need to be stable before IDLE.
- Reset values: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, grant_cnt=0, rr_ptr=0, hold_cnt=0.
- Reset asserted mid-grant clears gnt asynchronously, with no timeout pulse. After deassertion, arbitration restarts from rr_ptr=0.

## Timing
- Request-to-grant latency: req sampled high in IDLE at edge k gives gnt at k+1.
- Release: req[owner] sampled low at edge k gives gnt=0 from k+1 (RECOVER). The next grant appears at k+3 at the earliest, after one IDLE evaluation cycle.
- Maximum grant length: HOLD_MAX cycles of gnt high.
  - timeout is high during the first RECOVER cycle.
  - gnt=0 during that same cycle.
- All outputs are registered. There is no combinational path from req to gnt.
- Simultaneous release of the owner and a new request from another index: handled by the normal RECOVER → IDLE sequence, with no fast path.
- rr_ptr wrap-around: owner NUM_REQ-1 sets rr_ptr to 0.

## Structure
- A shared package holds the FSM state enum, the localparam for ID width ($clog2(NUM_REQ)), and a function for rotating first-set search.
- One sub-module is natural: rr_pick. It is a combinational priority search with inputs req and rr_ptr and outputs found and idx, instantiated once.
- Counters and the FSM stay in the top module.

## Test plan
- Reset, then single req=5'b00100 held for 3 cycles and dropped. Expected:
  - gnt=00100 one cycle after req.
  - gnt_id=2 for 3 cycles, then gnt=0.
  - grant_cnt=1.
  - rr_ptr=3.
- req=5'b11111 held continuously, each owner dropping after 2 cycles. Expected grant order 0,1,2,3,4,0, with exactly one gnt=0 cycle plus one IDLE cycle between grants.
- req[1] held high for 20 cycles with HOLD_MAX=16. Expected:
  - gnt[1] high for exactly 16 cycles.
  - timeout pulses once.
  - gnt[1] is re-granted 2 cycles later because no other requesters are pending.
- req[4] owner and req[0] pending, with rr_ptr wrap. Expected: after release of 4, gnt[0] asserts 2 cycles later.
- rst_n pulled low mid-grant of index 3. Expected:
  - gnt clears immediately, asynchronously.
  - timeout stays 0.
  - After release with req=5'b01001, gnt[0] is granted first.
- Force grant_cnt near 16'hFFFF with repeated grants. Expected: the counter saturates at 16'hFFFF and does not wrap.
